rob_commit_unit: RTL

In-order retirement stage on the read side of the reorder buffer. Each cycle it inspects the ROB head and retires it once the entry is marked complete: it pops the entry, updates the retirement RAT (RRAT), and returns the superseded physical register to the free list. On a mispredicted branch at the head it raises the pipeline-wide flush, supplies the redirect PC, and holds the RRAT snapshot stable while the front end recovers.

---
 rtl/rob_commit_unit.sv | 122 ++++++++++++
 1 files changed

// File: rtl/rob_commit_unit.sv
// In-order ROB retirement: pops completed heads, updates the RRAT, frees superseded
// pregs, and drives flush/redirect on a mispredicted head. Optional RVFI: COMMIT_RVFI_EN.
module rob_commit_unit #(
  parameter int unsigned NUM_PREGS  = 64,
  parameter int unsigned FLUSH_HOLD = 2,
  localparam int unsigned PHYS_W    = $clog2(NUM_PREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rob_empty,
  input  logic                head_commit,
  input  logic                head_regf_we,
  input  logic [4:0]          head_rd,
  input  logic [PHYS_W-1:0]   head_pd,
  input  logic                head_is_branch,
  input  logic [31:0]         head_pred_pc,
  input  logic [31:0]         head_calc_pc,
  output logic                dequeue,
  output logic                free_valid,
  output logic [PHYS_W-1:0]   free_preg,
  input  logic                free_ready,
  output logic                branch_mispredict,
  output logic [31:0]         redirect_pc,
  output logic                recover_busy,
  output logic [32*PHYS_W-1:0] rrat_map,
  output logic                rvfi_valid,
  output logic [63:0]         rvfi_order
);

  localparam int unsigned CntW = (FLUSH_HOLD > 1) ? $clog2(FLUSH_HOLD) : 1;

  typedef enum logic [1:0] {StRun, StFlush, StHold} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [PHYS_W-1:0] rrat_q [32];
  logic [31:0]       redirect_pc_q;
  logic              cand, needs_free, mispredict;

  // Free handshake and dequeue complete together; free_valid never waits on free_ready.
  always_comb begin
    cand       = (state_q == StRun) && !rob_empty && head_commit;
    needs_free = head_regf_we && (head_rd != 5'd0);
    free_valid = cand && needs_free;
    free_preg  = rrat_q[head_rd];
    dequeue    = cand && (!needs_free || free_ready);
    mispredict = dequeue && head_is_branch && (head_calc_pc != head_pred_pc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StRun;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      StRun: begin
        if (mispredict) state_d = StFlush;
      end
      StFlush: begin
        state_d    = StHold;
        hold_cnt_d = CntW'(FLUSH_HOLD - 1);
      end
      StHold: begin
        if (hold_cnt_q == '0) state_d = StRun;
        else                  hold_cnt_d = hold_cnt_q - CntW'(1);
      end
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    branch_mispredict = (state_q == StFlush);
    recover_busy      = (state_q != StRun);
    redirect_pc       = redirect_pc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rrat_q[i] <= PHYS_W'(i);
      redirect_pc_q <= '0;
    end else begin
      if (dequeue && needs_free) rrat_q[head_rd] <= head_pd;
      if (mispredict)            redirect_pc_q   <= head_calc_pc;
    end
  end

  always_comb begin
    rrat_map = '0;
    for (int i = 0; i < 32; i++) rrat_map[i*PHYS_W +: PHYS_W] = rrat_q[i];
  end

`ifdef COMMIT_RVFI_EN
  logic        rvfi_valid_q;
  logic [63:0] rvfi_order_q;

  // Order advances after each report, so a report carries the count of prior retirements.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvfi_valid_q <= 1'b0;
      rvfi_order_q <= '0;
    end else begin
      rvfi_valid_q <= dequeue;
      if (rvfi_valid_q) rvfi_order_q <= rvfi_order_q + 64'd1;
    end
  end

  assign rvfi_valid = rvfi_valid_q;
  assign rvfi_order = rvfi_order_q;
`else
  assign rvfi_valid = 1'b0;
  assign rvfi_order = 64'd0;
`endif

endmodule
